// File: rtl/upsp_pkg.sv
// Package shared by the up-sampling output-buffer read path.
// Holds the pixel geometry of a stream beat and the encoding of the
// read-sequencer states.
package upsp_pkg;

    localparam int PIX_WIDTH    = 24;
    localparam int PIX_PER_BEAT = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        STREAM = ST_STREAM,
        DRAIN  = ST_DRAIN,
        DONE   = ST_DONE
    } rd_state_t;

endpackage

// File: rtl/upsp_axis_oreg.sv
// Single-stage AXI4-Stream output register carrying tdata/tuser/tlast.
// load  : capture in_* and raise tvalid (caller guarantees the slot is free
//         or being handed over this cycle)
// hold  : payload frozen while tvalid & ~tready
// clear : tvalid drops after a handshake that is not refilled
// Ports: clk, rst_n (async, active-low), load, in_data/in_user/in_last,
//        tready in; tvalid/tdata/tuser/tlast out.
module upsp_axis_oreg #(
    parameter int DATA_WIDTH = 96
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_user,
    input  logic                  in_last,
    input  logic                  tready,
    output logic                  tvalid,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tuser,
    output logic                  tlast
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tuser  <= 1'b0;
            tlast  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= in_data;
            tuser  <= in_user;
            tlast  <= in_last;
        end else if (tvalid && tready) begin
            // Payload is left as-is; only tvalid is meaningful once empty.
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/upsp_outbuf_rdctrl.sv
// Read-side sequencer of the up-sampling output buffer.
// Pops 4-pixel words from a first-word-fall-through buffer and streams one
// frame per start pulse on an AXI4-Stream master (tuser = start of frame,
// tlast = end of row). One beat per clock when the sink never stalls.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 1-clk pulse, begin one frame (ignored unless idle)
//   busy, frame_done      status: busy from start to done inclusive
//   buf_empty, buf_rdata  buffer head (FWFT), buf_rd pops the head
//   m_axis_*              AXI4-Stream master
module upsp_outbuf_rdctrl
    import upsp_pkg::*;
#(
    parameter int DATA_WIDTH     = 96,
    parameter int DST_IMG_WIDTH  = 4096,
    parameter int DST_IMG_HEIGHT = 2160
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    input  logic                  buf_empty,
    input  logic [DATA_WIDTH-1:0] buf_rdata,
    output logic                  buf_rd,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast
);

    localparam int BEATS_PER_ROW = DST_IMG_WIDTH / PIX_PER_BEAT;
    localparam int COL_W = (BEATS_PER_ROW  > 1) ? $clog2(BEATS_PER_ROW)  : 1;
    localparam int ROW_W = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(BEATS_PER_ROW - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DST_IMG_HEIGHT - 1);

    rd_state_t        state_reg;
    logic [COL_W-1:0] col_cnt_reg;
    logic [ROW_W-1:0] row_cnt_reg;
    logic             busy_reg;
    logic             frame_done_reg;

    logic ld_en;
    logic load;
    logic col_last;
    logic row_last;
    logic first_beat;

    // Only the streaming state may pop; the register must be empty or be
    // emptied by a handshake in the same cycle.
    assign ld_en      = (state_reg == STREAM);
    assign load       = ld_en & ~buf_empty & (~m_axis_tvalid | m_axis_tready);
    assign buf_rd     = load;

    assign col_last   = (col_cnt_reg == COL_LAST);
    assign row_last   = (row_cnt_reg == ROW_LAST);
    assign first_beat = (col_cnt_reg == '0) && (row_cnt_reg == '0);

    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            col_cnt_reg    <= '0;
            row_cnt_reg    <= '0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= STREAM;
                        busy_reg    <= 1'b1;
                        col_cnt_reg <= '0;
                        row_cnt_reg <= '0;
                    end
                end
                STREAM: begin
                    // Counters follow pops, not handshakes, so framing tags
                    // are attached to the word at the moment it is captured.
                    if (load) begin
                        if (col_last && row_last) begin
                            state_reg <= DRAIN;
                        end else if (col_last) begin
                            col_cnt_reg <= '0;
                            row_cnt_reg <= row_cnt_reg + ROW_W'(1);
                        end else begin
                            col_cnt_reg <= col_cnt_reg + COL_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // The final beat sits in the output register; wait for it.
                    if (m_axis_tvalid && m_axis_tready) begin
                        state_reg      <= DONE;
                        frame_done_reg <= 1'b1;
                    end
                end
                DONE: begin
                    // start here is deliberately dropped.
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    upsp_axis_oreg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_oreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .in_data (buf_rdata),
        .in_user (first_beat),
        .in_last (col_last),
        .tready  (m_axis_tready),
        .tvalid  (m_axis_tvalid),
        .tdata   (m_axis_tdata),
        .tuser   (m_axis_tuser),
        .tlast   (m_axis_tlast)
    );

endmodule
